// File: rtl/moore_seq_gen_pkg.sv
// Shared definitions for the Moore serial pattern generator: state encoding
// and default pattern constants.
package moore_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int         PAT_W_DEFAULT   = 4;
  localparam int         CNT_W_DEFAULT   = 4;
  localparam logic [3:0] PATTERN_DEFAULT = 4'b1001;

endpackage

// File: rtl/moore_seq_gen.sv
// Moore FSM serial pattern generator: shifts PATTERN out MSB-first, repeated
// repeat_cnt times, optionally with a single '0' gap bit between repeats.
module moore_seq_gen
  import moore_seq_pkg::*;
#(
  parameter int               PAT_W   = PAT_W_DEFAULT,
  parameter logic [PAT_W-1:0] PATTERN = PATTERN_DEFAULT,
  parameter int               CNT_W   = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic             gap_en,
  output logic             data,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int               IDX_W    = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_next;
  logic [CNT_W-1:0] r_rem;
  logic [CNT_W-1:0] w_rem_next;
  logic             r_gap_q;
  logic             w_gap_next;

  logic r_data;
  logic r_valid;
  logic r_busy;
  logic r_done;
  logic w_data_next;
  logic w_valid_next;
  logic w_busy_next;
  logic w_done_next;

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_rem_next   = r_rem;
    w_gap_next   = r_gap_q;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_rem_next   = repeat_cnt;
          w_gap_next   = gap_en;
          w_idx_next   = IDX_LAST;
          w_state_next = (repeat_cnt != '0) ? ST_SEND : ST_DONE;
        end
      end
      ST_SEND: begin
        if (r_idx != '0) begin
          w_idx_next = r_idx - IDX_W'(1);
        end else begin
          // rem is always >= 1 while sending, so this cannot underflow
          w_rem_next = r_rem - CNT_W'(1);
          w_idx_next = IDX_LAST;
          if (r_rem > CNT_W'(1)) begin
            w_state_next = r_gap_q ? ST_GAP : ST_SEND;
          end else begin
            w_state_next = ST_DONE;
          end
        end
      end
      ST_GAP: begin
        w_idx_next   = IDX_LAST;
        w_state_next = ST_SEND;
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so that, once registered, they
  // line up with the state register while having no input-to-output path.
  always_comb begin
    w_data_next  = 1'b0;
    w_valid_next = 1'b0;
    w_busy_next  = 1'b0;
    w_done_next  = 1'b0;
    case (w_state_next)
      ST_SEND: begin
        w_data_next  = PATTERN[w_idx_next];
        w_valid_next = 1'b1;
        w_busy_next  = 1'b1;
      end
      ST_GAP: begin
        w_busy_next = 1'b1;
      end
      ST_DONE: begin
        w_done_next = 1'b1;
      end
      default: begin
        w_data_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_rem   <= '0;
      r_gap_q <= 1'b0;
      r_data  <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_rem   <= w_rem_next;
      r_gap_q <= w_gap_next;
      r_data  <= w_data_next;
      r_valid <= w_valid_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
    end
  end

  assign data  = r_data;
  assign valid = r_valid;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_moore_seq_gen.sv
// Directed self-checking bench for moore_seq_gen: per-cycle expected data,
// valid, busy and done vectors written out by hand.
module tb_moore_seq_gen;

  logic       clk;
  logic       rstn;
  logic       start;
  logic [3:0] repeat_cnt;
  logic       gap_en;
  logic       data;
  logic       valid;
  logic       busy;
  logic       done;

  int n_tests;
  int n_fail;

  moore_seq_gen dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .repeat_cnt (repeat_cnt),
    .gap_en     (gap_en),
    .data       (data),
    .valid      (valid),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic d, input logic v, input logic b, input logic dn);
    check_val($sformatf("%s data", tag), {31'd0, data}, {31'd0, d});
    check_val($sformatf("%s valid", tag), {31'd0, valid}, {31'd0, v});
    check_val($sformatf("%s busy", tag), {31'd0, busy}, {31'd0, b});
    check_val($sformatf("%s done", tag), {31'd0, done}, {31'd0, dn});
  endtask

  // Expected vectors read left to right in time: bit [len-1] is cycle 1.
  // At cycle inj (if nonzero) a stray start is pulsed with new repeat_cnt/gap_en.
  task automatic run_seq(input string tag, input logic [3:0] cnt, input logic gap,
                         input int len, input logic [31:0] ed, input logic [31:0] ev,
                         input logic [31:0] eb, input logic [31:0] edn, input int inj);
    int fails_before;
    fails_before = n_fail;
    @(negedge clk);
    repeat_cnt = cnt;
    gap_en     = gap;
    start      = 1'b1;
    for (int i = 1; i <= len; i++) begin
      @(negedge clk);
      check_outs($sformatf("%s c%0d", tag, i), ed[len-i], ev[len-i], eb[len-i], edn[len-i]);
      start = (i == inj);
      if (i == inj) begin
        repeat_cnt = 4'd1;
        gap_en     = 1'b1;
      end
    end
    start = 1'b0;
    $display("[TB] %s: cnt=%0d gap=%0d cycles=%0d errors=%0d", tag, cnt, gap, len,
             n_fail - fails_before);
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rstn       = 1'b0;
    start      = 1'b0;
    repeat_cnt = 4'd0;
    gap_en     = 1'b0;

    repeat (2) @(negedge clk);
    check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    rstn = 1'b1;
    @(negedge clk);
    check_outs("idle", 1'b0, 1'b0, 1'b0, 1'b0);

    run_seq("basic", 4'd1, 1'b0, 6,
            32'b100100, 32'b111100, 32'b111100, 32'b000010, 0);
    run_seq("b2b", 4'd2, 1'b0, 10,
            32'b1001100100, 32'b1111111100, 32'b1111111100, 32'b0000000010, 0);
    run_seq("gap", 4'd2, 1'b1, 11,
            32'b10010100100, 32'b11110111100, 32'b11111111100, 32'b00000000010, 0);
    run_seq("zero", 4'd0, 1'b0, 3,
            32'b000, 32'b000, 32'b000, 32'b100, 0);
    run_seq("ignore", 4'd3, 1'b0, 14,
            32'b10011001100100, 32'b11111111111100, 32'b11111111111100,
            32'b00000000000010, 3);

    // Reset mid-transfer: drop rstn between edges during cycle 3
    @(negedge clk);
    repeat_cnt = 4'd2;
    gap_en     = 1'b0;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_outs("rst_mid c1", 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check_outs("rst_mid c2", 1'b0, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    check_outs("rst_mid c3 pre", 1'b0, 1'b1, 1'b1, 1'b0);
    rstn = 1'b0;
    #1;
    check_outs("rst_mid async", 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check_outs("rst_mid held", 1'b0, 1'b0, 1'b0, 1'b0);
    rstn = 1'b1;
    @(negedge clk);
    check_outs("rst_mid idle", 1'b0, 1'b0, 1'b0, 1'b0);
    $display("[TB] reset mid-transfer: errors so far=%0d", n_fail);

    run_seq("after_rst", 4'd1, 1'b0, 6,
            32'b100100, 32'b111100, 32'b111100, 32'b000010, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/moore_seq_gen.md
Name: moore_seq_gen

Overview:
- Moore FSM serial pattern generator: the transmitting end for the team's Moore non-overlapping sequence detector.
- On a start request it shifts a fixed PAT_W-bit pattern out MSB-first, one bit per clock, repeated a programmable number of times.
- Repeats go back-to-back or separated by a single idle '0' gap bit.
- Used as a stimulus and loopback source for the detector and as a framing-pattern source in serial links.

Parameters:
- PAT_W, 4, pattern length in bits (>=2).
- PATTERN, 4'b1001, pattern transmitted MSB first.
- CNT_W, 4, width of repeat count.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rstn  input  1  reset, asynchronous, active-low.
- start  input  1  request transmission; sampled only in IDLE.
- repeat_cnt  input  CNT_W  number of pattern repetitions; latched with start.
- gap_en  input  1  1 = insert one '0' gap bit between repetitions; latched with start.
- data  output  1  serial pattern bit (registered).
- valid  output  1  high while data carries a pattern bit.
- busy  output  1  high in SEND and GAP.
- done  output  1  one-cycle completion pulse.

Interface decision: one clock, clk; reset rstn is asynchronous and active-low.

Behaviour:
- Pure Moore machine. All outputs are decoded from registered state, index and counters only; no input-to-output combinational path.
- Reset (rstn=0, any time including mid-transfer): state=IDLE, data=0, valid=0, busy=0, done=0, counters cleared. Takes effect immediately, with no clock needed.
- States:
  - IDLE: data=0, valid=0, busy=0, done=0.
  - SEND: data=PATTERN[idx], valid=1, busy=1.
  - GAP: data=0, valid=0, busy=1.
  - DONE: done=1, all other outputs 0.
- IDLE, start=1 at edge k:
  - Latch repeat_cnt into rem and gap_en into gap_q.
  - If repeat_cnt!=0: go to SEND with idx=PAT_W-1; the first bit is visible after edge k.
  - If repeat_cnt==0: go to DONE (done pulse after edge k, no bits emitted).
- SEND, idx>0: idx decrements; stay in SEND.
- SEND, idx==0 (last bit of a repetition), with rem decremented at this edge:
  - rem>1 and gap_q=1: go to GAP.
  - rem>1 and gap_q=0: stay in SEND with idx=PAT_W-1.
  - rem==1: go to DONE.
- GAP: always lasts one cycle, then SEND with idx=PAT_W-1.
- DONE: always lasts one cycle, then IDLE. done is high for exactly one cycle.
- start is ignored in SEND, GAP and DONE. No queuing; a new start is accepted only in IDLE.
- repeat_cnt and gap_en changes after latching have no effect on the current transfer.
- Latency: first bit 1 cycle after the start edge.
- Total busy cycles = N*PAT_W + (gap_q ? N-1 : 0), where N = latched repeat_cnt.
- Maximum N = 2^CNT_W-1, with no wrap. The rem counter never underflows because it is only decremented when rem>=1.

Decomposition:
- Shared package moore_seq_pkg:
  - state encoding localparams ST_IDLE=2'd0, ST_SEND=2'd1, ST_GAP=2'd2, ST_DONE=2'd3.
  - default PATTERN constant 4'b1001.
- No sub-module required. The bit index and repeat counter are small in-module registers.
- The FSM next-state logic and output decode go in separate always blocks.

Test Plan:
- Basic: repeat_cnt=1, gap_en=0, start one cycle -> data 1,0,0,1 with valid=1 on cycles 1-4; done=1 on cycle 5 only; busy high on cycles 1-4.
- Back-to-back: repeat_cnt=2, gap_en=0 -> data 1,0,0,1,1,0,0,1 on cycles 1-8 with valid continuously 1; done on cycle 9.
- Gap: repeat_cnt=2, gap_en=1 -> data 1,0,0,1,0,1,0,0,1; valid=0 only on cycle 5; busy high on cycles 1-9; done on cycle 10.
- Zero count: repeat_cnt=0, start -> valid and busy never assert; done=1 on cycle 1; back in IDLE on cycle 2.
- Start ignored and late inputs: repeat_cnt=3; pulse start again and change repeat_cnt=1 on cycle 3 -> exactly 12 pattern bits sent; a single done on cycle 13.
- Reset mid-transfer: repeat_cnt=2; drop rstn on cycle 3 (asynchronous, between edges) -> data, valid, busy and done go 0 immediately. After release, a fresh start with repeat_cnt=1 gives a clean 1,0,0,1.
